rx_sync_ctrl: RTL and testbench
===============================

RX_SYNC_CTRL -- requirements
Module: rx_sync_ctrl

Interface
REQ-001 SHALL have parameter GOOD_RUN, 4, count of consecutive error-free symbols that cancels one error in SYNC_ERR.
REQ-002 SHALL have parameter ERR_LIMIT, 4, accumulated error count that forces loss of sync.
REQ-003 SHALL have parameter TIMEOUT, 63, number of clocks without sym_valid that forces loss of sync (range 2..255).
REQ-004 SHALL have port clk  in  1  bit/recovered clock; single clock domain.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port sym_valid  in  1  one-cycle strobe per aligned 10-bit symbol (from the comma detector's RxValid).
REQ-007 SHALL have port is_comma  in  1  current symbol is K28.5 (either disparity); qualified by sym_valid.
REQ-008 SHALL have port code_err  in  1  decode or running-disparity error on current symbol; qualified by sym_valid.
REQ-009 SHALL have port cfg_comma_number  in  3  requested consecutive commas for lock (valid 1..4).
REQ-010 SHALL have port COMMA_NUMBER  out  3  registered, clamped comma count driven to the comma detector.
REQ-011 SHALL have port sync_ok  out  1  link symbol-synchronised.
REQ-012 SHALL have port realign  out  1  one-cycle pulse requesting detector re-search.
REQ-013 SHALL have port err_cnt  out  3  current accumulated error count.
REQ-014 SHALL have port los_events  out  8  saturating count of sync losses.

Function
REQ-015 SHALL implement FSM states LOS, ACQ, SYNC, SYNC_ERR; all transitions registered on clk.
REQ-016 SHALL ignore is_comma and code_err in any cycle where sym_valid=0.
REQ-017 SHALL treat a symbol with is_comma=1 and code_err=1 as an error, not a comma.
REQ-018 SHALL, in LOS only, load COMMA_NUMBER from cfg_comma_number clamped (0->1, 5..7->4); in other states COMMA_NUMBER holds.
REQ-019 LOS: on a valid error-free comma, SHALL go to SYNC if COMMA_NUMBER==1, else go to ACQ with comma_cnt=1.
REQ-020 ACQ: an error symbol SHALL return to LOS; an error-free comma SHALL increment comma_cnt and go to SYNC when comma_cnt reaches COMMA_NUMBER; error-free non-comma symbols SHALL hold state and count.
REQ-021 SYNC: an error symbol SHALL go to SYNC_ERR with err_cnt=1, good_cnt=0.
REQ-022 SYNC_ERR: an error symbol SHALL increment err_cnt and clear good_cnt; when err_cnt reaches ERR_LIMIT the FSM SHALL go to LOS.
REQ-023 SYNC_ERR: an error-free symbol SHALL increment good_cnt; at GOOD_RUN it SHALL decrement err_cnt and clear good_cnt; err_cnt reaching 0 SHALL return to SYNC.
REQ-024 sync_ok SHALL be 1 exactly while the registered state is SYNC or SYNC_ERR.
REQ-025 SHALL run an 8-bit watchdog in ACQ/SYNC/SYNC_ERR, cleared by sym_valid, incrementing otherwise; reaching TIMEOUT SHALL force LOS.
REQ-026 sym_valid in the cycle the watchdog would reach TIMEOUT SHALL win (watchdog cleared, no LOS).
REQ-027 Every transition into LOS from a non-LOS state SHALL assert realign for exactly the following cycle and increment los_events (saturating at 255).
REQ-028 err_cnt, comma_cnt, good_cnt and watchdog SHALL clear on entry to LOS.

Reset
REQ-029 SHALL on rst_n=0 asynchronously set state LOS, COMMA_NUMBER=1, sync_ok=0, realign=0, err_cnt=0, los_events=0, all internal counters 0.
REQ-030 Reset assertion mid-lock SHALL NOT pulse realign nor increment los_events.

Structure
REQ-031 State enum and default GOOD_RUN/ERR_LIMIT/TIMEOUT constants SHALL live in shared package rx_sync_pkg.
REQ-032 SHALL be a single module with no sub-modules; comma detector instantiation belongs to the PCS RX top.

Verification
REQ-033 cfg=3; three error-free comma strobes -> sync_ok=1 the cycle after the third; COMMA_NUMBER=3.
REQ-034 cfg=2; comma, then code_err symbol -> back to LOS, sync_ok stays 0, realign pulses once, los_events=1.
REQ-035 In SYNC, ERR_LIMIT=4: error, 4 good, error, error -> err_cnt 1,0(SYNC),1,2; then 2 more errors -> LOS, realign=1.
REQ-036 In SYNC, no sym_valid for 63 clocks -> LOS on the 63rd; repeat with sym_valid on cycle 63 -> stays SYNC.
REQ-037 cfg=0 and cfg=7 -> COMMA_NUMBER 1 and 4; changing cfg while in SYNC -> COMMA_NUMBER unchanged.
REQ-038 Force 256 losses -> los_events saturates at 255; rst_n low mid-SYNC -> all outputs at reset values, no realign.

Source files
------------

// File: rtl/rx_sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_sync_pkg : shared state type, default constants, comma clamp      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package rx_sync_pkg;

  typedef enum logic [1:0] {
    LOS      = 2'd0,
    ACQ      = 2'd1,
    SYNC     = 2'd2,
    SYNC_ERR = 2'd3
  } sync_state_e;

  localparam int DEF_GOOD_RUN  = 4;
  localparam int DEF_ERR_LIMIT = 4;
  localparam int DEF_TIMEOUT   = 63;

  // The detector only understands 1..4 consecutive commas.
  function automatic logic [2:0] clamp_comma(input logic [2:0] cfg);
    logic [2:0] res;
    res = cfg;
    if (cfg == 3'd0) begin
      res = 3'd1;
    end else if (cfg > 3'd4) begin
      res = 3'd4;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_sync_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_sync_ctrl : PCS receive symbol-synchronisation state machine      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module rx_sync_ctrl
  import rx_sync_pkg::*;
#(
  parameter int GOOD_RUN  = DEF_GOOD_RUN,
  parameter int ERR_LIMIT = DEF_ERR_LIMIT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic       is_comma,
  input  logic       code_err,
  input  logic [2:0] cfg_comma_number,
  output logic [2:0] COMMA_NUMBER,
  output logic       sync_ok,
  output logic       realign,
  output logic [2:0] err_cnt,
  output logic [7:0] los_events
);

  localparam logic [7:0] GOOD_RUN_C  = 8'(GOOD_RUN);
  localparam logic [2:0] ERR_LIMIT_C = 3'(ERR_LIMIT);
  localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

  sync_state_e state_q, state_d;
  logic [2:0]  comma_num_q, comma_num_d;
  logic [2:0]  comma_cnt_q, comma_cnt_d;
  logic [2:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  wd_q, wd_d;
  logic        realign_q, realign_d;
  logic [7:0]  los_q, los_d;
  logic        lost;

  logic sym_bad, sym_good, sym_comma;
  assign sym_bad   = sym_valid & code_err;
  assign sym_good  = sym_valid & ~code_err;
  assign sym_comma = sym_good & is_comma;

  always_comb begin
    state_d     = state_q;
    comma_num_d = comma_num_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    wd_d        = wd_q;
    lost        = 1'b0;

    case (state_q)
      LOS: begin
        comma_num_d = clamp_comma(cfg_comma_number);
        if (sym_comma) begin
          if (comma_num_q == 3'd1) begin
            state_d = SYNC;
          end else begin
            state_d     = ACQ;
            comma_cnt_d = 3'd1;
          end
        end
      end
      ACQ: begin
        if (sym_bad) begin
          state_d = LOS;
        end else if (sym_comma) begin
          comma_cnt_d = comma_cnt_q + 3'd1;
          if (comma_cnt_q + 3'd1 >= comma_num_q) begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        if (sym_bad) begin
          state_d    = SYNC_ERR;
          err_cnt_d  = 3'd1;
          good_cnt_d = 8'd0;
        end
      end
      SYNC_ERR: begin
        if (sym_bad) begin
          err_cnt_d  = err_cnt_q + 3'd1;
          good_cnt_d = 8'd0;
          if (err_cnt_q + 3'd1 >= ERR_LIMIT_C) begin
            state_d = LOS;
          end
        end else if (sym_good) begin
          if (good_cnt_q + 8'd1 >= GOOD_RUN_C) begin
            good_cnt_d = 8'd0;
            err_cnt_d  = err_cnt_q - 3'd1;
            if (err_cnt_q == 3'd1) begin
              state_d = SYNC;
            end
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = LOS;
    endcase

    // A valid symbol in the would-be timeout cycle rescues the link.
    if (state_q != LOS) begin
      if (sym_valid) begin
        wd_d = 8'd0;
      end else if (wd_q + 8'd1 >= TIMEOUT_C) begin
        state_d = LOS;
      end else begin
        wd_d = wd_q + 8'd1;
      end
    end

    if ((state_q != LOS) && (state_d == LOS)) begin
      lost        = 1'b1;
      comma_cnt_d = 3'd0;
      err_cnt_d   = 3'd0;
      good_cnt_d  = 8'd0;
      wd_d        = 8'd0;
    end

    realign_d = lost;
    los_d     = (lost && (los_q != 8'hFF)) ? los_q + 8'd1 : los_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOS;
      comma_num_q <= 3'd1;
      comma_cnt_q <= 3'd0;
      err_cnt_q   <= 3'd0;
      good_cnt_q  <= 8'd0;
      wd_q        <= 8'd0;
      realign_q   <= 1'b0;
      los_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      comma_num_q <= comma_num_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      wd_q        <= wd_d;
      realign_q   <= realign_d;
      los_q       <= los_d;
    end
  end

  assign COMMA_NUMBER = comma_num_q;
  assign sync_ok      = (state_q == SYNC) || (state_q == SYNC_ERR);
  assign realign      = realign_q;
  assign err_cnt      = err_cnt_q;
  assign los_events   = los_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_sync_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rx_sync_ctrl : random + directed scoreboard bench for rx_sync_ctrl|
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_rx_sync_ctrl;

  localparam int GOOD_RUN  = 4;
  localparam int ERR_LIMIT = 4;
  localparam int TIMEOUT   = 63;

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic       is_comma;
  logic       code_err;
  logic [2:0] cfg_comma_number;
  logic [2:0] COMMA_NUMBER;
  logic       sync_ok;
  logic       realign;
  logic [2:0] err_cnt;
  logic [7:0] los_events;

  rx_sync_ctrl #(
    .GOOD_RUN (GOOD_RUN),
    .ERR_LIMIT(ERR_LIMIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sym_valid       (sym_valid),
    .is_comma        (is_comma),
    .code_err        (code_err),
    .cfg_comma_number(cfg_comma_number),
    .COMMA_NUMBER    (COMMA_NUMBER),
    .sync_ok         (sync_ok),
    .realign         (realign),
    .err_cnt         (err_cnt),
    .los_events      (los_events)
  );

  typedef struct packed {
    logic [2:0] cn;
    logic       ok;
    logic       ra;
    logic [2:0] ec;
    logic [7:0] le;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: link is locked, hunting for commas, or lost.
  bit m_locked, m_hunting, m_realign;
  int m_need, m_seen, m_errs, m_goods, m_idle, m_losses;

  task automatic model_reset();
    m_locked = 0; m_hunting = 0; m_realign = 0;
    m_need = 1; m_seen = 0; m_errs = 0; m_goods = 0; m_idle = 0; m_losses = 0;
  endtask

  task automatic model_step(input bit v, input bit c, input bit e, input int cfg);
    bit good, bad, comma, drop;
    good  = v && !e;
    bad   = v && e;
    comma = good && c;
    drop  = 0;
    m_realign = 0;
    if (!m_locked && !m_hunting) begin
      if (comma) begin
        if (m_need == 1) m_locked = 1;
        else begin m_hunting = 1; m_seen = 1; end
      end
      m_need = (cfg == 0) ? 1 : (cfg > 4) ? 4 : cfg;
    end else begin
      if (m_hunting) begin
        if (bad) drop = 1;
        else if (comma) begin
          m_seen++;
          if (m_seen == m_need) begin m_hunting = 0; m_locked = 1; end
        end
      end else begin
        if (bad) begin
          m_errs++; m_goods = 0;
          if (m_errs == ERR_LIMIT) drop = 1;
        end else if (good && m_errs > 0) begin
          m_goods++;
          if (m_goods == GOOD_RUN) begin m_goods = 0; m_errs--; end
        end
      end
      if (v) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TIMEOUT) drop = 1;
      end
      if (drop) begin
        m_locked = 0; m_hunting = 0; m_seen = 0; m_errs = 0; m_goods = 0; m_idle = 0;
        m_realign = 1;
        if (m_losses < 255) m_losses++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t r;
    r.cn = 3'(m_need);
    r.ok = m_locked;
    r.ra = m_realign;
    r.ec = 3'(m_errs);
    r.le = 8'(m_losses);
    return r;
  endfunction

  task automatic step(input bit v, input bit c, input bit e, input logic [2:0] cfg);
    @(negedge clk);
    rst_n = 1'b1; sym_valid = v; is_comma = c; code_err = e; cfg_comma_number = cfg;
    model_step(v, c, e, int'(cfg));
    exp_q.push_back(model_out());
  endtask

  // Reset pulse released before the next rising edge, so only an async reset takes effect.
  task automatic do_reset(input logic [2:0] cfg);
    @(negedge clk);
    rst_n = 1'b0; sym_valid = 0; is_comma = 0; code_err = 0; cfg_comma_number = cfg;
    #3 rst_n = 1'b1;
    model_reset();
    model_step(0, 0, 0, int'(cfg));
    exp_q.push_back(model_out());
  endtask

  always begin : p_monitor
    exp_t e_v, a_v;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      a_v = {COMMA_NUMBER, sync_ok, realign, err_cnt, los_events};
      n_checks++;
      if (a_v === e_v) n_pass++;
      else $display("FAIL outputs @%0t: got cn=%0d ok=%0d ra=%0d ec=%0d le=%0d, required cn=%0d ok=%0d ra=%0d ec=%0d le=%0d",
                    $time, a_v.cn, a_v.ok, a_v.ra, a_v.ec, a_v.le, e_v.cn, e_v.ok, e_v.ra, e_v.ec, e_v.le);
    end
  end

  initial begin : p_stim
    logic [2:0] cfg;
    rst_n = 1'b0; sym_valid = 0; is_comma = 0; code_err = 0; cfg_comma_number = 3'd1;
    model_reset();

    // three-comma lock
    do_reset(3'd3);
    repeat (3) step(1, 1, 0, 3'd3);
    step(1, 0, 0, 3'd3);

    // error while acquiring
    do_reset(3'd2);
    step(1, 1, 0, 3'd2);
    step(1, 0, 1, 3'd2);
    step(0, 0, 0, 3'd2);

    // error accounting in sync
    do_reset(3'd1);
    step(1, 1, 0, 3'd1);
    step(1, 0, 1, 3'd1);
    repeat (4) step(1, 0, 0, 3'd1);
    repeat (4) step(1, 0, 1, 3'd1);
    step(0, 0, 0, 3'd1);

    // watchdog: rescue on the last cycle, then a real timeout
    do_reset(3'd1);
    step(1, 1, 0, 3'd1);
    repeat (TIMEOUT - 1) step(0, 0, 0, 3'd1);
    step(1, 0, 0, 3'd1);
    repeat (TIMEOUT) step(0, 0, 0, 3'd1);
    step(0, 0, 0, 3'd1);

    // comma-count clamping and hold outside LOS
    do_reset(3'd0);
    step(0, 0, 0, 3'd0);
    do_reset(3'd7);
    repeat (4) step(1, 1, 0, 3'd7);
    repeat (3) step(1, 0, 0, 3'd2);

    // saturate loss counter, then reset while locked
    do_reset(3'd2);
    repeat (260) begin
      step(1, 1, 0, 3'd2);
      step(1, 0, 1, 3'd2);
    end
    step(1, 1, 0, 3'd2);
    step(1, 1, 0, 3'd2);
    do_reset(3'd2);
    step(0, 0, 0, 3'd2);

    // randomized traffic
    cfg = 3'd2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cfg = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) do_reset(cfg);
      else if ($urandom_range(0, 199) == 0) begin
        repeat ($urandom_range(55, 70)) step(0, 0, 0, cfg);
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, cfg);
      end
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
